rgb_expander_pipe: RTL and testbench

Parametrised colour-expansion pipeline between the pixel source (time/segment renderer) and the VGA DAC pins. It widens CHANNELS colour channels from IN_W to OUT_W bits by bit replication and applies a per-pixel display mode: pass, blink, dim or blank. It carries pixels over a valid/ready stream with two register stages and full throughput.

---
 rtl/rgb_expander_pipe_pkg.sv | 31 +++
 rtl/rgb_expander_pipe_if.sv | 29 ++
 rtl/rgb_expander_pipe_chan_scale.sv | 33 +++
 rtl/rgb_expander_pipe.sv | 107 ++++++++++
 tb/tb_rgb_expander_pipe.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/rgb_expander_pipe_pkg.sv
// Shared display types and the channel bit-replication helper.
// Pure declarations: no state, no latency, no flow control.
package display_pkg;

  typedef enum logic [1:0] {
    PASS  = 2'b00,
    BLINK = 2'b01,
    DIM   = 2'b10,
    BLANK = 2'b11
  } color_mode_e;

  localparam int MAX_CHAN_W = 8;

  // Repeat the in_w-bit value MSB-first and keep the top out_w bits; result is
  // right-aligned in 8 bits so callers of any width can take the low bits.
  function automatic logic [MAX_CHAN_W-1:0] expand_chan(
    input logic [MAX_CHAN_W-1:0] value,
    input int                    in_w,
    input int                    out_w
  );
    logic [MAX_CHAN_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_CHAN_W; i++) begin
      if (i < out_w) begin
        r[3'(out_w - 1 - i)] = value[3'(in_w - 1 - (i % in_w))];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rgb_expander_pipe_if.sv
// Pixel stream bundle: input pixel with its mode/brightness, output colour.
// Valid/ready on both sides; the slave modport is the pipeline's view.
interface rgb_expander_pipe_if #(
  parameter int IN_W     = 2,
  parameter int OUT_W    = 4,
  parameter int CHANNELS = 3,
  parameter int FADE_W   = 4
);

  logic                       in_valid;
  logic                       in_ready;
  logic [CHANNELS*IN_W-1:0]   in_color;
  display_pkg::color_mode_e   mode;
  logic [FADE_W-1:0]          brightness;
  logic                       out_valid;
  logic                       out_ready;
  logic [CHANNELS*OUT_W-1:0]  out_color;

  modport master (
    output in_valid, in_color, mode, brightness, out_ready,
    input  in_ready, out_valid, out_color
  );

  modport slave (
    input  in_valid, in_color, mode, brightness, out_ready,
    output in_ready, out_valid, out_color
  );

endinterface

// File: rtl/rgb_expander_pipe_chan_scale.sv
// One colour channel: applies PASS/BLINK/DIM/BLANK to an expanded value.
// Purely combinational, no handshake of its own.
module chan_scale
  import display_pkg::*;
#(
  parameter int OUT_W  = 4,
  parameter int FADE_W = 4
) (
  input  logic [OUT_W-1:0]  i_exp,
  input  color_mode_e       i_mode,
  input  logic [FADE_W-1:0] i_bright,
  input  logic              i_phase,
  output logic [OUT_W-1:0]  o_chan
);

  localparam int PW = OUT_W + FADE_W + 1;

  logic [PW-1:0] w_prod;

  // brightness+1 so that the all-ones code is an exact identity after >> FADE_W
  assign w_prod = PW'(i_exp) * (PW'(i_bright) + PW'(1));

  always_comb begin
    o_chan = '0;
    case (i_mode)
      PASS:  o_chan = i_exp;
      BLINK: o_chan = i_phase ? '0 : i_exp;
      DIM:   o_chan = w_prod[FADE_W +: OUT_W];
      BLANK: o_chan = '0;
    endcase
  end

endmodule

// File: rtl/rgb_expander_pipe.sv
// Widens packed RGB channels and applies a per-pixel display mode; 2 register stages.
// Latency 2 cycles, 1 pixel/cycle; in_ready follows out_ready combinationally when full.
module rgb_expander_pipe
  import display_pkg::*;
#(
  parameter int IN_W       = 2,
  parameter int OUT_W      = 4,
  parameter int CHANNELS   = 3,
  parameter int FADE_W     = 4,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  rgb_expander_pipe_if.slave pix
);

  localparam int CW_OUT = CHANNELS * OUT_W;
  localparam int CNT_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CNT_W-1:0]  r_blink_cnt;
  logic              r_blink_phase;

  logic              r_v1;
  logic [CW_OUT-1:0] r_exp1;
  color_mode_e       r_mode1;
  logic [FADE_W-1:0] r_bright1;
  logic              r_phase1;

  logic              r_v2;
  logic [CW_OUT-1:0] r_col2;

  logic              w_s1_load;
  logic              w_s2_load;
  logic              w_in_acc;
  logic [CW_OUT-1:0] w_exp;
  logic [CW_OUT-1:0] w_scaled;

  assign w_s2_load = !r_v2 || pix.out_ready;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign w_in_acc  = pix.in_valid && w_s1_load;

  assign pix.in_ready  = w_s1_load;
  assign pix.out_valid = r_v2;
  assign pix.out_color = r_col2;

  // Free-running blink timer, independent of the pixel handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == CNT_W'(BLINK_HALF - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign w_exp[c*OUT_W +: OUT_W] =
      OUT_W'(expand_chan(8'(pix.in_color[c*IN_W +: IN_W]), IN_W, OUT_W));

    chan_scale #(
      .OUT_W  (OUT_W),
      .FADE_W (FADE_W)
    ) u_scale (
      .i_exp    (r_exp1[c*OUT_W +: OUT_W]),
      .i_mode   (r_mode1),
      .i_bright (r_bright1),
      .i_phase  (r_phase1),
      .o_chan   (w_scaled[c*OUT_W +: OUT_W])
    );
  end

  // Stage 1: expanded colour plus the mode context sampled at acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_exp1    <= '0;
      r_mode1   <= PASS;
      r_bright1 <= '0;
      r_phase1  <= 1'b0;
    end else if (w_s1_load) begin
      r_v1 <= pix.in_valid;
      if (w_in_acc) begin
        r_exp1    <= w_exp;
        r_mode1   <= pix.mode;
        r_bright1 <= pix.brightness;
        r_phase1  <= r_blink_phase;
      end
    end
  end

  // Stage 2: out_color only moves when the downstream slot is free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2   <= 1'b0;
      r_col2 <= '0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_col2 <= w_scaled;
      end
    end
  end

endmodule

// File: tb/tb_rgb_expander_pipe.sv
// Directed bench for rgb_expander_pipe: latency, modes, blink, backpressure, reset.
module tb_rgb_expander_pipe;
  import display_pkg::*;

  localparam int IN_W = 2, OUT_W = 4, CH = 3, FW = 4, BH = 4;

  logic clk;
  logic reset;

  rgb_expander_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .FADE_W(FW)) pix();

  rgb_expander_pipe #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .FADE_W(FW), .BLINK_HALF(BH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pix   (pix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int          edges = 0;
  logic        acc, rdy_seen, ov_seen;
  logic [11:0] oc_seen, hold;
  logic [11:0] exp_q[$];

  // Posedges since reset release; the blink phase is (edges/BH) % 2.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, score any output transfer.
  task automatic cycle(input logic v, input logic [5:0] c, input color_mode_e m,
                       input logic [3:0] b, input logic ordy, input logic [11:0] expc);
    logic [11:0] e;
    @(negedge clk);
    pix.in_valid   = v;
    pix.in_color   = c;
    pix.mode       = m;
    pix.brightness = b;
    pix.out_ready  = ordy;
    #1;
    rdy_seen = pix.in_ready;
    ov_seen  = pix.out_valid;
    oc_seen  = pix.out_color;
    acc      = v && rdy_seen;
    e = expc;
    if (m == BLINK && ((edges / BH) % 2) == 1) e = '0;
    if (ov_seen && ordy) begin
      n_out++;
      if (exp_q.size() == 0) check("extra_out", 32'(exp_q.size()), 32'd1);
      else                   check("stream", 32'(oc_seen), 32'(exp_q.pop_front()));
    end
    if (acc) exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, PASS, '0, 1'b1, '0);
  endtask

  // {B,G,R}: 2->4 replication maps 0,1,2,3 to 0,5,A,F
  logic [5:0]  bp_in  [8] = '{6'b00_00_00, 6'b00_00_01, 6'b00_01_10, 6'b01_10_11,
                              6'b11_11_11, 6'b10_01_00, 6'b11_00_10, 6'b01_11_01};
  logic [11:0] bp_exp [8] = '{12'h000, 12'h005, 12'h05A, 12'h5AF,
                              12'hFFF, 12'hA50, 12'hF0A, 12'h5F5};

  localparam logic [5:0] PIX_A = 6'b11_10_01;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, k, n0;
    reset = 1'b1;
    pix.in_valid = 1'b0; pix.in_color = '0; pix.mode = PASS;
    pix.brightness = '0; pix.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", 32'(pix.out_valid), 32'd0);
    check("rst_out_color", 32'(pix.out_color), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(pix.in_ready), 32'd1);

    // Expansion helper at other widths
    check("exp_3to8", 32'(expand_chan(8'b101, 3, 8)), 32'b1011_0110);
    check("exp_5to4", 32'(expand_chan(8'b10111, 5, 4)), 32'b1011);
    check("exp_2to4", 32'(expand_chan(8'b01, 2, 4)), 32'b0101);

    // Latency: visible in the second cycle after the accept edge
    cycle(1'b1, PIX_A, PASS, 4'hF, 1'b1, 12'hFA5);
    check("lat_accept", 32'(acc), 32'd1);
    cycle(1'b0, '0, PASS, '0, 1'b1, '0);
    check("lat_c1_vld", 32'(ov_seen), 32'd0);
    cycle(1'b0, '0, PASS, '0, 1'b1, '0);
    check("lat_c2_vld", 32'(ov_seen), 32'd1);
    check("lat_c2_col", 32'(oc_seen), 32'hFA5);

    // Back-to-back mode / brightness changes, each sampled with its pixel
    cycle(1'b1, PIX_A, DIM,   4'd7, 1'b1, 12'h752);
    cycle(1'b1, PIX_A, DIM,   4'hF, 1'b1, 12'hFA5);
    cycle(1'b1, PIX_A, BLANK, 4'hF, 1'b1, 12'h000);
    cycle(1'b1, PIX_A, PASS,  4'd0, 1'b1, 12'hFA5);
    cycle(1'b1, PIX_A, DIM,   4'd0, 1'b1, 12'h000);
    cycle(1'b1, PIX_A, DIM,   4'd8, 1'b1, 12'h852);
    flush(3);
    check("modes_drained", 32'(exp_q.size()), 32'd0);

    // Blink: one pixel per cycle, 4-on / 4-off by acceptance cycle
    for (int i = 0; i < 16; i++) cycle(1'b1, PIX_A, BLINK, 4'hF, 1'b1, 12'hFA5);
    flush(3);
    check("blink_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: out_ready low for loop cycles 3..5
    n0 = n_out; idx = 0; k = 0;
    while (idx < 8 && k < 40) begin
      cycle(1'b1, bp_in[idx], PASS, 4'hF, !(k >= 3 && k <= 5), bp_exp[idx]);
      if (k == 3 || k == 4) check("bp_in_ready_low", 32'(rdy_seen), 32'd0);
      if (k == 3) hold = oc_seen;
      if (k == 4 || k == 5) check("bp_hold", 32'(oc_seen), 32'(hold));
      if (acc) idx++;
      k++;
    end
    check("bp_all_sent", 32'(idx), 32'd8);
    flush(4);
    check("bp_count", 32'(n_out - n0), 32'd8);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two pixels in flight
    cycle(1'b1, PIX_A, PASS, 4'hF, 1'b0, 12'hFA5);
    cycle(1'b1, 6'b01_01_01, PASS, 4'hF, 1'b0, 12'h555);
    @(negedge clk);
    pix.in_valid = 1'b0;
    #1;
    check("mid_pre_vld", 32'(pix.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_vld", 32'(pix.out_valid), 32'd0);
    check("mid_rst_col", 32'(pix.out_color), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 6'b10_10_10, PASS, 4'hF, 1'b1, 12'hAAA);
    check("post_rst_rdy", 32'(rdy_seen), 32'd1);
    cycle(1'b0, '0, PASS, '0, 1'b1, '0);
    check("post_c1_vld", 32'(ov_seen), 32'd0);
    cycle(1'b0, '0, PASS, '0, 1'b1, '0);
    check("post_c2_vld", 32'(ov_seen), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b1, PIX_A, BLINK, 4'hF, 1'b1, 12'hFA5);
    flush(3);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
